// File: rtl/vga_fb_pkg.sv
// Shared constants and writer state type for the VGA framebuffer arbiter.
package vga_fb_pkg;

   localparam int unsigned H_START  = 144;
   localparam int unsigned V_START  = 31;
   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_H     = 120;
   localparam int unsigned ACT_W    = 640;
   localparam int unsigned ACT_H    = 480;
   localparam int unsigned SCALE_SH = 2;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned PIX_W    = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } wr_state_e;

endpackage

// File: rtl/vga_fb_arbiter_addr_gen.sv
// fb_addr_gen: combinational framebuffer address, y*160+x as shift-and-add.
module fb_addr_gen
   import vga_fb_pkg::*;
(
   input  logic [7:0]        x,
   input  logic [6:0]        y,
   output logic [ADDR_W-1:0] addr
);

   always_comb begin
      addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display fetch every 4 pixel clocks, writer gets the rest.
// Define FB_VBLANK_ONLY_EN to restrict in-range writes to non-active lines.
module vga_fb_arbiter
   import vga_fb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              wr_req,
   input  logic [7:0]        wr_x,
   input  logic [6:0]        wr_y,
   input  logic [PIX_W-1:0]  wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  rgb
);

   localparam int unsigned STEP    = 1 << SCALE_SH;
   localparam logic [9:0]  V_FIRST = 10'(V_START);
   localparam logic [9:0]  V_LAST  = 10'(V_START + ACT_H - 1);
   localparam logic [9:0]  F_FIRST = 10'(H_START - STEP);
   localparam logic [9:0]  F_LAST  = 10'(H_START + ACT_W - 2 * STEP);
   localparam logic [9:0]  R_FIRST = 10'(H_START - 1);
   localparam logic [9:0]  R_LAST  = 10'(H_START + ACT_W - STEP - 1);
   localparam logic [9:0]  R_BLANK = 10'(H_START + ACT_W - 1);

   wr_state_e          state_q, state_d;
   logic               err_q;
   logic               fetch_q;
   logic [PIX_W-1:0]   pix_next;
   logic [PIX_W-1:0]   rgb_q, rgb_d;

   logic               active_line, fetch_slot, in_range, wr_open, grant, reject;
   logic [9:0]         vrel, hrel;
   logic [7:0]         disp_x;
   logic [6:0]         disp_y;
   logic [ADDR_W-1:0]  disp_addr, wr_addr;

   always_comb begin
      vrel        = vcount - V_FIRST;
      hrel        = hcount - F_FIRST;
      disp_y      = 7'(vrel >> SCALE_SH);
      disp_x      = 8'(hrel >> SCALE_SH);
      active_line = (vcount >= V_FIRST) && (vcount <= V_LAST);
      fetch_slot  = active_line && (hcount >= F_FIRST) && (hcount <= F_LAST) &&
                    (hcount[SCALE_SH-1:0] == '0);
      in_range    = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
`ifdef FB_VBLANK_ONLY_EN
      wr_open     = !fetch_slot && !active_line;
`else
      wr_open     = !fetch_slot;
`endif
      grant       = (state_q == IDLE) && wr_req && in_range && wr_open;
      reject      = (state_q == IDLE) && wr_req && !in_range;
      state_d     = (grant || reject) ? ACK : IDLE;
   end

   fb_addr_gen u_disp_addr (
      .x    (disp_x),
      .y    (disp_y),
      .addr (disp_addr)
   );

   fb_addr_gen u_wr_addr (
      .x    (wr_x),
      .y    (wr_y),
      .addr (wr_addr)
   );

   always_comb begin
      mem_addr  = fetch_slot ? disp_addr : wr_addr;
      mem_we    = grant && !rst;
      mem_wdata = wr_data;
      wr_ack    = (state_q == ACK);
      wr_err    = err_q;
      rgb       = rgb_q;
   end

   // rgb advances on the last clock of each 4-pixel cell, so the new column lands on its edge.
   always_comb begin
      rgb_d = rgb_q;
      if (!active_line || (hcount == R_BLANK)) begin
         rgb_d = '0;
      end else if ((hcount >= R_FIRST) && (hcount <= R_LAST) &&
                   (&hcount[SCALE_SH-1:0])) begin
         rgb_d = pix_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         err_q    <= 1'b0;
         fetch_q  <= 1'b0;
         pix_next <= '0;
         rgb_q    <= '0;
      end else begin
         state_q <= state_d;
         if (reject) begin
            err_q <= 1'b1;
         end
         fetch_q <= fetch_slot;
         if (fetch_q) begin
            pix_next <= mem_rdata;
         end
         rgb_q <= rgb_d;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: random writes against a framebuffer/scan-out model.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hcount, vcount;
   logic        wr_req;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [7:0]  wr_data;
   logic        wr_ack, wr_err, mem_we;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, rgb;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] ram      [0:32767];
   logic [7:0] ref_fb   [0:19199];
   logic [7:0] line_pix [0:159];
   bit m_ack = 1'b0;
   bit m_err = 1'b0;
   bit acked = 1'b0;
   int sched_h = -1;
   int sched_x, sched_y, sched_d;
   int rate = 0;

   always #5 clk = ~clk;

   vga_fb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .hcount    (hcount),
      .vcount    (vcount),
      .wr_req    (wr_req),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_err    (wr_err),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .rgb       (rgb)
   );

   // Synchronous single-port RAM, preloaded with addr[7:0] while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 8'(i);
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at h=%0d v=%0d: got %0d expected %0d", tag, hcount, vcount, got, exp);
      end
   endtask

   // Compares one cycle at mid-period, then advances the model and the clock.
   task automatic step();
      int a, row, col, expv;
      bit act, slot, inr, open;
      #4;
      act  = (vcount >= 31) && (vcount <= 510);
      slot = act && (hcount >= 140) && (hcount <= 776) && (hcount % 4 == 0);
      row  = (int'(vcount) - 31) / 4;
      col  = (int'(hcount) - 140) / 4;
      inr  = (wr_x < 160) && (wr_y < 120);
      open = !slot;
`ifdef FB_VBLANK_ONLY_EN
      open = open && !act;
`endif
      expv = (act && hcount >= 144 && hcount <= 783) ? int'(line_pix[(int'(hcount) - 144) / 4]) : 0;
      if (rst) expv = 0;
      check_eq("rgb", rgb, expv);
      check_eq("wr_ack", wr_ack, rst ? 0 : m_ack);
      check_eq("wr_err", wr_err, rst ? 0 : m_err);
      acked = m_ack && !rst;
      if (rst) begin
         check_eq("we_in_reset", mem_we, 0);
         m_ack = 1'b0;
         m_err = 1'b0;
      end else if (m_ack) begin
         check_eq("we_in_ack", mem_we, 0);
         m_ack = 1'b0;
      end else if (wr_req && !inr) begin
         check_eq("we_reject", mem_we, 0);
         m_err = 1'b1;
         m_ack = 1'b1;
      end else if (wr_req && open) begin
         a = int'(wr_y) * 160 + int'(wr_x);
         check_eq("we_grant", mem_we, 1);
         check_eq("wr_addr", mem_addr, a);
         check_eq("wr_data", mem_wdata, wr_data);
         ref_fb[a] = wr_data;
         m_ack = 1'b1;
      end else begin
         check_eq("we_idle", mem_we, 0);
      end
      if (slot && !rst) begin
         a = row * 160 + col;
         check_eq("rd_addr", mem_addr, a);
         line_pix[col] = ref_fb[a];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_writer();
      if (acked) wr_req = 1'b0;
      if (!wr_req) begin
         if (int'(hcount) == sched_h) begin
            wr_req  = 1'b1;
            wr_x    = 8'(sched_x);
            wr_y    = 7'(sched_y);
            wr_data = 8'(sched_d);
            sched_h = -1;
         end else if (rate != 0 && $urandom_range(rate - 1, 0) == 0) begin
            wr_req  = 1'b1;
            wr_x    = ($urandom_range(15, 0) == 0) ? 8'($urandom_range(255, 160))
                                                   : 8'($urandom_range(159, 0));
            wr_y    = 7'($urandom_range(127, 0));
            wr_data = 8'($urandom);
         end
      end
   endtask

   task automatic run_line(input int v);
      for (int h = 0; h < 800; h++) begin
         hcount = 10'(h);
         vcount = 10'(v);
         drive_writer();
         step();
      end
   endtask

   task automatic sched(input int h, input int x, input int y, input int d);
      sched_h = h;
      sched_x = x;
      sched_y = y;
      sched_d = d;
   endtask

   initial begin
      rst     = 1'b1;
      hcount  = 10'd0;
      vcount  = 10'd0;
      wr_req  = 1'b1;
      wr_x    = 8'd3;
      wr_y    = 7'd3;
      wr_data = 8'h77;
      for (int i = 0; i < 19200; i++) ref_fb[i] = 8'(i);
      for (int i = 0; i < 160; i++) line_pix[i] = 8'd0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         hcount = 10'(300 + i);
         step();
      end
      rst    = 1'b0;
      wr_req = 1'b0;

      run_line(30);
      run_line(31);
      run_line(32);

      sched(10, 5, 2, 8'hA5);
      run_line(40);
      run_line(41);
      run_line(0);
      run_line(39);

      sched(144, 7, 1, 8'h3C);
      run_line(50);
      run_line(0);
      run_line(35);

      sched(20, 160, 0, 8'h99);
      run_line(0);
      sched(40, 1, 1, 8'h11);
      run_line(1);

      sched(300, 10, 10, 8'h5A);
      run_line(100);
      run_line(101);
      run_line(510);
      run_line(511);
      run_line(71);

      rate = 3;
      for (int i = 0; i < 34; i++) begin
         if ($urandom_range(2, 0) == 0) run_line(int'($urandom_range(524, 511)));
         else run_line(int'($urandom_range(510, 31)));
      end
      rate = 0;
      run_line(520);
      run_line(int'($urandom_range(510, 31)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer arbiter and scan-out sequencer between the VGA timing generator and a single-port 160x120x8 framebuffer RAM. Using the generator's `hcount`/`vcount`, it issues one display read per 4 pixel clocks on active lines, scaling each stored pixel to 4x4 screen pixels. All remaining RAM cycles go to a drawing writer through a req/ack handshake. Sits between the timing generator, the framebuffer RAM and the colour DAC pins.

## Interface
- `H_START`, 144: first active hcount; must be a multiple of 4
- `V_START`, 31: first active vcount
- `FB_W`, 160: framebuffer width in pixels
- `FB_H`, 120: framebuffer height in pixels
- `clk  in  1`: pixel clock, the same clock as the timing generator
- `rst  in  1`: reset, asynchronous, active-high
- `hcount  in  10`: horizontal count from the timing generator
- `vcount  in  10`: vertical count from the timing generator
- `wr_req  in  1`: write request; held with x/y/data stable until `wr_ack`
- `wr_x  in  8`: pixel column
- `wr_y  in  7`: pixel row
- `wr_data  in  8`: pixel colour
- `wr_ack  out  1`: one-cycle pulse; the write is done or rejected
- `wr_err  out  1`: sticky; set by an out-of-range write, cleared only by reset
- `mem_addr  out  15`: RAM address
- `mem_we  out  1`: RAM write enable
- `mem_wdata  out  8`: RAM write data
- `mem_rdata  in  8`: RAM read data; valid the cycle after its address
- `rgb  out  8`: registered pixel colour; 0 outside the active window

## Operation
- Active line: V_START <= vcount <= V_START+479.
- Row = (vcount-V_START)>>2.
- Fetch slot: active line AND H_START-4 <= hcount <= H_START+632 AND hcount[1:0]==0.
- Column at a fetch slot = (hcount+4-H_START)>>2, giving 0..159.
- In a fetch slot: mem_addr = row*160+col, mem_we=0. Display always wins the slot.
- Address arithmetic: y*160+x = (y<<7)+(y<<5)+x, 15 bits unsigned, no overflow for in-range x/y.
- Writer FSM has two states, IDLE and ACK.
- IDLE, wr_req=1, coordinates in range, not a fetch slot:
  - mem_we=1, mem_addr=wr_y*160+wr_x, mem_wdata=wr_data, all combinational this cycle.
  - Next state ACK.
- IDLE, wr_req=1, coordinates in range, fetch slot: stall in IDLE. No RAM activity for the writer.
- IDLE, wr_req=1, wr_x>=160 or wr_y>=120:
  - No RAM write; the fetch slot is irrelevant.
  - wr_err<=1, next state ACK.
- ACK: wr_ack=1 for exactly one cycle, no grant in this state, then back to IDLE.
- Maximum write throughput: one write per 2 cycles.
- No fetch slot and no grant: mem_we=0, mem_addr holds the writer address (don't-care).

## Timing
- Read latency: address issued at hcount=h; mem_rdata sampled into internal pix_next at the end of cycle h+1.
- rgb loads pix_next on the edge where hcount goes H_START+4c-1 -> H_START+4c, while on an active line.
- rgb therefore holds column c for hcount H_START+4c .. H_START+4c+3.
- rgb loads 0 on the edge entering hcount H_START+640, and on every edge while not on an active line.
- Write commit is on the edge ending the grant cycle. wr_ack is high in the following cycle.
- Reset values: rgb=0, wr_ack=0, wr_err=0, FSM=IDLE, pix_next=0.
- mem_we is forced to 0 while rst is high, even if wr_req is high.
- Reset asserted in ACK: the ack is lost. The writer must re-request after reset.
- Simultaneous wr_req and fetch slot: the fetch wins; the write is granted in the next non-slot cycle.

## Configuration
- `FB_VBLANK_ONLY_EN`, when defined: writes are granted only while vcount is outside the active lines (tear-free update). In-range requests on active lines stall in IDLE. Out-of-range requests are still rejected immediately.
- When undefined: writes are granted in any non-fetch cycle, as described above.

## Structure
- Package `vga_fb_pkg` holds:
  - H_START, V_START, FB_W, FB_H, the active widths 640/480 and the scale shift 2
  - address width 15 and pixel width 8
  - the writer FSM state enum {IDLE, ACK}
- One natural sub-module, `fb_addr_gen`: combinational (x,y)->y*160+x. It is instantiated twice, once for the display path and once for the writer path, with a mux on mem_addr.

## Test plan
- Reset with wr_req=1: mem_we=0 and rgb=0 throughout reset. After release, the FSM is IDLE and wr_ack=0.
- RAM model preloaded with addr[7:0]; line vcount=31:
  - rgb=0x00 for hcount 144..147, then 0x01 for 148..151.
  - Column 159 at hcount 780..783; rgb=0 from hcount 784.
- Write (x=5, y=2, data=0xA5) during hblank:
  - mem_we=1 with mem_addr=325 for one cycle, wr_ack the next cycle.
  - A later scan of row 2 shows 0xA5 at hcount 164..167.
- wr_req rising at hcount=144 on an active line (fetch slot): the grant is at hcount=145 and wr_ack at 146.
- Write with x=160, y=0: no mem_we, wr_ack after 1 cycle, wr_err=1 and stays set through later valid writes.
- With `FB_VBLANK_ONLY_EN` defined, request at vcount=100: no grant until vcount=511, then a normal write and ack.
